rst_release_seq: RTL and testbench
==================================

# rst_release_seq

Reset-release sequencer that generates the active-low asynchronous reset nets driving the RN pins of downstream reset-flop (dffrnq-type) banks. Reset assertion is asynchronous to every domain. Deassertion is synchronised to CLK, held off for a programmable settle time, then released one domain at a time in a fixed order. A READY flag reports when all domains are out of reset.

## Interface
- SYNC_STAGES, 2, depth of the deassert synchroniser chain (legal ≥2)
- HOLD_CYCLES, 16, settle cycles between synchronised release and RNO[0] rising (legal ≥1)
- STEP_CYCLES, 4, cycles between successive domain releases (legal ≥1)
- DOMAINS, 3, number of sequenced reset outputs (legal 1..8)

- CLK  input  1  clock, rising-edge
- RN  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- SRST  input  1  synchronous active-high soft-reset request, already in the CLK domain
- RNO  output  DOMAINS  active-low domain resets; bit 0 released first
- READY  output  1  high when all RNO bits are released

## Operation
- Reset values while RN=0: RNO = all 0, READY = 0, sync chain = 0, state = RESET, counter = 0. All of these are forced asynchronously on RN falling; no clock is needed.
- Synchroniser: SYNC_STAGES flops, all async-cleared by RN, D of the first stage tied to 1. Its output is sync_rn.
- FSM states:
  - RESET: RNO = 0, READY = 0. When sync_rn = 1, go to HOLD with cnt = 0.
  - HOLD: RNO = 0. cnt increments each edge. On an edge where cnt == HOLD_CYCLES-1: set RNO[0] = 1, cnt = 0, go to RELEASE (or to RUN if DOMAINS = 1).
  - RELEASE: idx tracks the next domain to release. cnt increments. On an edge where cnt == STEP_CYCLES-1: set RNO[idx] = 1 and cnt = 0. After RNO[DOMAINS-1] is set, go to RUN on the next edge.
  - RUN: READY = 1, all RNO = 1.
- SRST: on any edge with SRST = 1 and state ≠ RESET:
  - RNO ← 0, READY ← 0, state ← HOLD, cnt ← 0, idx ← 1.
  - While SRST stays high, the block holds HOLD with cnt = 0.
- RN = 0 overrides SRST and everything else at any time, including mid-sequence.
- An RN low pulse shorter than one CLK period must still fully reset all state.
- Released RNO bits never fall except through RN or SRST.
- RNO and READY are driven directly from flops; no combinational path from inputs to outputs.
- cnt width = clog2(max(HOLD_CYCLES, STEP_CYCLES)). idx width = clog2(DOMAINS) + 1. No wrap is possible; compare only on the exact terminal count.

## Timing
- Edge 1 is the first CLK rise after RN rises. Relative to edge 1:
  - sync_rn = 1 after edge SYNC_STAGES.
  - FSM enters HOLD at edge SYNC_STAGES+1.
  - RNO[0] rises at edge SYNC_STAGES+HOLD_CYCLES+1.
  - RNO[i] rises STEP_CYCLES·i edges after RNO[0].
  - READY rises one edge after RNO[DOMAINS-1].
- Defaults: RNO[0] at 19, RNO[1] at 23, RNO[2] at 27, READY at 28.
- SRST: let E be the last edge sampling SRST = 1. RNO[0] rises at E+HOLD_CYCLES, and the step spacing is as above.
- RN removal too close to CLK may cost at most one extra synchroniser cycle. Both outcomes are legal, and the bench must tolerate ±1 edge.

## Structure
- Shared include/package holds the FSM state encoding localparams (RESET, HOLD, RELEASE, RUN), a clog2 function, and parameter legality checks (elaboration-time error on illegal values).
- One sub-module, rst_sync_chain (parameter STAGES; ports CLK, RN, Q), built from the library's dffrnq cell so that reset-recovery timing is characterised.
- Top level contains the FSM, cnt, idx and RNO/READY registers, all async-cleared by RN.

## Test plan
- Power-up with defaults: RN low for 3 cycles, then high → RNO = 000 until edge 19; 001 at 19, 011 at 23, 111 at 27; READY = 1 at 28.
- RN pulsed low for 0.3 of a CLK period while in RUN → RNO = 000 and READY = 0 immediately (before the next edge); the full sequence then repeats with the same edge counts.
- RN asserted mid-sequence at edge 21 (RNO = 001) → RNO returns to 000 asynchronously; on re-release the timing is measured from the new edge 1.
- SRST high for one edge (E) in RUN → RNO = 000 and READY = 0 after E; RNO[0] at E+16, RNO[1] at E+20, RNO[2] at E+24, READY at E+25.
- SRST held high for 10 cycles during RELEASE → RNO stays 000 throughout; the release count starts from the last SRST-high edge; SRST with RN = 0 has no effect.
- DOMAINS=1, HOLD_CYCLES=1, SYNC_STAGES=3 → RNO[0] rises at edge 5 and READY at edge 6; an illegal parameter (SYNC_STAGES=1) fails elaboration.

Source files
------------

// File: rtl/rst_release_seq_pkg.sv
// Shared types and elaboration helpers for the reset-release sequencer.
package rst_release_seq_pkg;

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Counter must reach the larger of the two terminal counts; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned step);
        int unsigned w;
        w = clog2((hold > step) ? hold : step);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic bit params_legal(input int unsigned sync_stages,
                                        input int unsigned hold_cycles,
                                        input int unsigned step_cycles,
                                        input int unsigned domains);
        return (sync_stages >= 2) && (hold_cycles >= 1) && (step_cycles >= 1) &&
               (domains >= 1) && (domains <= 8);
    endfunction

endpackage

// File: rtl/rst_release_seq_sync_chain.sv
// Reset deassertion synchroniser: async clear, synchronous release of a constant 1.
module rst_sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic CLK,
    input  logic RN,
    output logic Q
);

    logic [STAGES-1:0] stage;

    // Each bit maps onto a dffrnq so recovery/removal against CLK is characterised.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            stage <= '0;
        end else begin
            stage <= {stage[STAGES-2:0], 1'b1};
        end
    end

    assign Q = stage[STAGES-1];

endmodule

// File: rtl/rst_release_seq.sv
// Sequenced reset release: synchronised deassert, settle hold, then one domain per step.
module rst_release_seq
    import rst_release_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STEP_CYCLES = 4,
    parameter int unsigned DOMAINS     = 3
) (
    input  logic               CLK,
    input  logic               RN,
    input  logic               SRST,
    output logic [DOMAINS-1:0] RNO,
    output logic               READY
);

    localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, STEP_CYCLES);
    localparam int unsigned IDX_W = clog2(DOMAINS) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_DONE  = IDX_W'(DOMAINS);

    if (!params_legal(SYNC_STAGES, HOLD_CYCLES, STEP_CYCLES, DOMAINS)) begin : g_param_check
        $error("rst_release_seq: illegal parameter combination");
    end

    logic             sync_rn;
    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;

    rst_sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .CLK(CLK),
        .RN (RN),
        .Q  (sync_rn)
    );

    // Sequencer; soft reset restarts the hold from any post-reset state.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state <= ST_RESET;
            cnt   <= '0;
            idx   <= '0;
            RNO   <= '0;
            READY <= 1'b0;
        end else if (SRST && (state != ST_RESET)) begin
            state <= ST_HOLD;
            cnt   <= '0;
            idx   <= IDX_W'(1);
            RNO   <= '0;
            READY <= 1'b0;
        end else begin
            case (state)
                ST_RESET: begin
                    if (sync_rn) begin
                        state <= ST_HOLD;
                        cnt   <= '0;
                    end
                end
                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        RNO[0] <= 1'b1;
                        cnt    <= '0;
                        idx    <= IDX_W'(1);
                        state  <= (DOMAINS == 1) ? ST_RUN : ST_RELEASE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    // Last domain went out on the previous edge; hand over to RUN.
                    if (idx == IDX_DONE) begin
                        state <= ST_RUN;
                        READY <= 1'b1;
                    end else if (cnt == STEP_LAST) begin
                        RNO <= RNO | (DOMAINS'(1) << idx);
                        idx <= idx + IDX_W'(1);
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    RNO   <= '1;
                    READY <= 1'b1;
                end
                default: begin
                    state <= ST_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_release_seq.sv
// Directed checks of release timing, async/short resets and soft-reset restarts.
module tb_rst_release_seq;

    typedef struct {
        int unsigned off;
        logic        srst;
        logic [2:0]  rno;
        logic        ready;
    } vec_t;

    logic       CLK;
    logic       RN;
    logic       SRST;
    logic [2:0] RNO;
    logic       READY;
    logic       rn1;
    logic       srst1;
    logic [0:0] rno1;
    logic       ready1;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    vec_t rel_tbl[$];
    vec_t srst_tbl[$];
    vec_t hold_tbl[$];
    vec_t tbl[$];

    rst_release_seq u_dut (
        .CLK  (CLK),
        .RN   (RN),
        .SRST (SRST),
        .RNO  (RNO),
        .READY(READY)
    );

    rst_release_seq #(
        .SYNC_STAGES(3),
        .HOLD_CYCLES(1),
        .STEP_CYCLES(4),
        .DOMAINS    (1)
    ) u_dut1 (
        .CLK  (CLK),
        .RN   (rn1),
        .SRST (srst1),
        .RNO  (rno1),
        .READY(ready1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic release_rn();
        @(negedge CLK);
        RN = 1'b1;
    endtask

    // Find RNO[0] rising; one extra synchroniser edge is tolerated.
    task automatic wait_e0(input string tag);
        int unsigned n;
        bit early;
        n = 0;
        early = 1'b0;
        for (int unsigned k = 1; k <= 40; k++) begin
            tick();
            n = k;
            if (RNO[0]) break;
            if ((RNO != 3'b000) || READY) early = 1'b1;
        end
        check({tag, ".early"}, 32'(early), 32'd0);
        check({tag, ".e0"}, n, (n == 20) ? 32'd20 : 32'd19);
        check({tag, ".rno_e0"}, 32'(RNO), 32'h1);
        check({tag, ".ready_e0"}, 32'(READY), 32'h0);
    endtask

    // Offsets in tbl are edges counted from the call point.
    task automatic play(input string tag);
        int unsigned cur;
        cur = 0;
        foreach (tbl[i]) begin
            SRST = tbl[i].srst;
            while (cur < tbl[i].off) begin
                tick();
                cur++;
            end
            check($sformatf("%s[%0d].rno", tag, i), 32'(RNO), 32'(tbl[i].rno));
            check($sformatf("%s[%0d].ready", tag, i), 32'(READY), 32'(tbl[i].ready));
        end
        SRST = 1'b0;
    endtask

    initial begin
        int unsigned n1;

        RN    = 1'b1;
        SRST  = 1'b0;
        rn1   = 1'b1;
        srst1 = 1'b0;

        // Relative to RNO[0] rising.
        rel_tbl.push_back('{1,  1'b0, 3'b001, 1'b0});
        rel_tbl.push_back('{3,  1'b0, 3'b001, 1'b0});
        rel_tbl.push_back('{4,  1'b0, 3'b011, 1'b0});
        rel_tbl.push_back('{7,  1'b0, 3'b011, 1'b0});
        rel_tbl.push_back('{8,  1'b0, 3'b111, 1'b0});
        rel_tbl.push_back('{9,  1'b0, 3'b111, 1'b1});
        rel_tbl.push_back('{12, 1'b0, 3'b111, 1'b1});

        // SRST sampled at offset 1 (edge E).
        srst_tbl.push_back('{1,  1'b1, 3'b000, 1'b0});
        srst_tbl.push_back('{16, 1'b0, 3'b000, 1'b0});
        srst_tbl.push_back('{17, 1'b0, 3'b001, 1'b0});
        srst_tbl.push_back('{20, 1'b0, 3'b001, 1'b0});
        srst_tbl.push_back('{21, 1'b0, 3'b011, 1'b0});
        srst_tbl.push_back('{24, 1'b0, 3'b011, 1'b0});
        srst_tbl.push_back('{25, 1'b0, 3'b111, 1'b0});
        srst_tbl.push_back('{26, 1'b0, 3'b111, 1'b1});

        // SRST held for 10 edges; last high edge is offset 10.
        for (int unsigned k = 1; k <= 10; k++) hold_tbl.push_back('{k, 1'b1, 3'b000, 1'b0});
        hold_tbl.push_back('{25, 1'b0, 3'b000, 1'b0});
        hold_tbl.push_back('{26, 1'b0, 3'b001, 1'b0});
        hold_tbl.push_back('{29, 1'b0, 3'b001, 1'b0});
        hold_tbl.push_back('{30, 1'b0, 3'b011, 1'b0});
        hold_tbl.push_back('{34, 1'b0, 3'b111, 1'b0});
        hold_tbl.push_back('{35, 1'b0, 3'b111, 1'b1});

        // Reset state, forced before any clock edge.
        #2;
        RN  = 1'b0;
        rn1 = 1'b0;
        #1;
        check("reset.rno", 32'(RNO), 32'h0);
        check("reset.ready", 32'(READY), 32'h0);
        check("reset1.rno", 32'(rno1), 32'h0);
        check("reset1.ready", 32'(ready1), 32'h0);
        repeat (3) tick();
        check("reset_clk.rno", 32'(RNO), 32'h0);
        check("reset_clk.ready", 32'(READY), 32'h0);

        // Power-up release.
        release_rn();
        wait_e0("pwr");
        tbl = rel_tbl;
        play("pwr");

        // Sub-cycle RN pulse while running.
        @(posedge CLK);
        #2 RN = 1'b0;
        #1;
        check("pulse.rno", 32'(RNO), 32'h0);
        check("pulse.ready", 32'(READY), 32'h0);
        #2 RN = 1'b1;
        wait_e0("pulse");
        play("pulse");

        // RN asserted mid-sequence, then re-released.
        RN = 1'b0;
        release_rn();
        wait_e0("mid_a");
        tick();
        tick();
        check("mid.rno21", 32'(RNO), 32'h1);
        #1 RN = 1'b0;
        #1;
        check("mid.rno_async", 32'(RNO), 32'h0);
        check("mid.ready_async", 32'(READY), 32'h0);
        repeat (2) @(negedge CLK);
        RN = 1'b1;
        wait_e0("mid_b");
        play("mid_b");

        // One-edge SRST from RUN.
        tbl = srst_tbl;
        play("srst1");

        // SRST held during RELEASE.
        #1 RN = 1'b0;
        release_rn();
        wait_e0("hold");
        tick();
        tick();
        tbl = hold_tbl;
        play("srsth");

        // SRST has no effect while RN is low.
        #1 RN = 1'b0;
        SRST = 1'b1;
        repeat (3) tick();
        check("srst_rn0.rno", 32'(RNO), 32'h0);
        check("srst_rn0.ready", 32'(READY), 32'h0);
        SRST = 1'b0;
        release_rn();
        wait_e0("after_rn0");
        tbl = rel_tbl;
        play("after_rn0");

        // Single-domain, short-hold, three-stage variant.
        @(negedge CLK);
        rn1 = 1'b1;
        n1 = 0;
        for (int unsigned k = 1; k <= 20; k++) begin
            tick();
            n1 = k;
            if (rno1[0]) break;
        end
        check("d1.e0", n1, (n1 == 6) ? 32'd6 : 32'd5);
        check("d1.ready_e0", 32'(ready1), 32'h0);
        tick();
        check("d1.rno_e1", 32'(rno1), 32'h1);
        check("d1.ready_e1", 32'(ready1), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
